// File: rtl/player_controller.sv
// ============================================================================
// Module      : player_controller
// Description : Per-frame player movement: run, jump, gravity, landing.
//               Optional macro PLAYER_DOUBLE_JUMP_EN adds one air jump.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_controller #(
    parameter int PLAYER_SIZE_X = 37,
    parameter int PLAYER_SIZE_Y = 42,
    parameter int SCREEN_W      = 640,
    parameter int GROUND_Y      = 400,
    parameter int START_X       = 100,
    parameter int RUN_SPEED     = 3,
    parameter int JUMP_VEL      = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 10
) (
    input  logic        VGA_clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [3:0]  game_state,
    output reg   [15:0] playerX,
    output reg   [15:0] playerY,
    output reg          player_dir,
    output reg   [3:0]  player_state
);

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_RUN  = 4'd1;
    localparam logic [3:0] c_ST_JUMP = 4'd2;
    localparam logic [3:0] c_ST_FALL = 4'd3;

    localparam logic [3:0] c_GS_START = 4'd0;
    localparam logic [3:0] c_GS_PLAY  = 4'd1;

    localparam logic signed [17:0] c_GY       = 18'(GROUND_Y - PLAYER_SIZE_Y);
    localparam logic signed [17:0] c_X_MAX    = 18'(SCREEN_W - PLAYER_SIZE_X);
    localparam logic signed [17:0] c_RUN      = 18'(RUN_SPEED);
    localparam logic signed [8:0]  c_JUMP_VY  = 9'(-JUMP_VEL);
    localparam logic signed [8:0]  c_GRAV     = 9'(GRAVITY);
    localparam logic signed [8:0]  c_MAX_FALL = 9'(MAX_FALL);

    reg               r_left_latch;
    reg               r_right_latch;
    reg               r_jump_latch;
    reg signed [7:0]  r_vy;

    logic               w_left;
    logic               w_right;
    logic               w_jump;
    logic               w_moving;
    logic               w_in_air;
    logic signed [17:0] w_x_sum;
    logic signed [17:0] w_y_sum;
    logic signed [8:0]  w_vy_sum;
    logic [15:0]        w_x_next;
    logic [15:0]        w_y_next;
    logic signed [7:0]  w_vy_next;
    logic               w_dir_next;
    logic [3:0]         w_state_next;

`ifdef PLAYER_DOUBLE_JUMP_EN
    reg   r_air_jumped;
    logic w_air_jumped_next;
`endif

    // A press anywhere inside the frame counts, even if released before the tick
    assign w_left   = r_left_latch  | btn_left;
    assign w_right  = r_right_latch | btn_right;
    assign w_jump   = r_jump_latch  | btn_jump;
    assign w_moving = w_left ^ w_right;

    always_comb begin
        w_x_next     = playerX;
        w_y_next     = playerY;
        w_vy_next    = r_vy;
        w_dir_next   = player_dir;
        w_state_next = player_state;
        w_in_air     = 1'b0;
        w_x_sum      = 18'(playerX);
        w_y_sum      = 18'(playerY);
        w_vy_sum     = 9'(r_vy);
`ifdef PLAYER_DOUBLE_JUMP_EN
        w_air_jumped_next = r_air_jumped;
`endif
        case (game_state)
            c_GS_START: begin
                w_x_next     = 16'(START_X);
                w_y_next     = c_GY[15:0];
                w_vy_next    = 8'sd0;
                w_dir_next   = 1'b0;
                w_state_next = c_ST_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
                w_air_jumped_next = 1'b0;
`endif
            end
            c_GS_PLAY: begin
                if (w_left && !w_right) begin
                    w_x_sum    = w_x_sum - c_RUN;
                    w_dir_next = 1'b1;
                end else if (w_right && !w_left) begin
                    w_x_sum    = w_x_sum + c_RUN;
                    w_dir_next = 1'b0;
                end
                if (w_x_sum < 18'sd0)
                    w_x_next = 16'd0;
                else if (w_x_sum > c_X_MAX)
                    w_x_next = c_X_MAX[15:0];
                else
                    w_x_next = w_x_sum[15:0];

                if (player_state == c_ST_IDLE || player_state == c_ST_RUN) begin
                    if (w_jump) begin
                        w_vy_sum     = c_JUMP_VY;
                        w_state_next = c_ST_JUMP;
                        w_in_air     = 1'b1;
                    end else begin
                        w_state_next = w_moving ? c_ST_RUN : c_ST_IDLE;
                    end
                end else begin
                    w_in_air = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (w_jump && !r_air_jumped) begin
                        w_vy_sum          = c_JUMP_VY;
                        w_air_jumped_next = 1'b1;
                    end else begin
                        w_vy_sum = w_vy_sum + c_GRAV;
                        if (w_vy_sum > c_MAX_FALL)
                            w_vy_sum = c_MAX_FALL;
                    end
`else
                    w_vy_sum = w_vy_sum + c_GRAV;
                    if (w_vy_sum > c_MAX_FALL)
                        w_vy_sum = c_MAX_FALL;
`endif
                    w_state_next = (w_vy_sum < 9'sd0) ? c_ST_JUMP : c_ST_FALL;
                end

                if (w_in_air) begin
                    w_y_sum = w_y_sum + 18'(w_vy_sum);
                    if (w_y_sum >= c_GY) begin
                        w_y_next     = c_GY[15:0];
                        w_vy_next    = 8'sd0;
                        w_state_next = w_moving ? c_ST_RUN : c_ST_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
                        w_air_jumped_next = 1'b0;
`endif
                    end else if (w_y_sum < 18'sd0) begin
                        // Head hit the top edge: stop and start falling
                        w_y_next     = 16'd0;
                        w_vy_next    = 8'sd0;
                        w_state_next = c_ST_FALL;
                    end else begin
                        w_y_next  = w_y_sum[15:0];
                        w_vy_next = w_vy_sum[7:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            playerX       <= 16'(START_X);
            playerY       <= c_GY[15:0];
            player_dir    <= 1'b0;
            player_state  <= c_ST_IDLE;
            r_vy          <= 8'sd0;
            r_left_latch  <= 1'b0;
            r_right_latch <= 1'b0;
            r_jump_latch  <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_jumped  <= 1'b0;
`endif
        end else if (frame_tick) begin
            playerX       <= w_x_next;
            playerY       <= w_y_next;
            player_dir    <= w_dir_next;
            player_state  <= w_state_next;
            r_vy          <= w_vy_next;
            r_left_latch  <= 1'b0;
            r_right_latch <= 1'b0;
            r_jump_latch  <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_jumped  <= w_air_jumped_next;
`endif
        end else begin
            r_left_latch  <= r_left_latch  | btn_left;
            r_right_latch <= r_right_latch | btn_right;
            r_jump_latch  <= r_jump_latch  | btn_jump;
        end
    end

endmodule

`default_nettype wire
